// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: FIFO-buffered A/B operand issuer for the 4x4 MAC.
// Issues len pairs spaced by GAP, zeros otherwise, and pulses done after the MAC drains.
module mac_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2,
  parameter int DRAIN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic                       start,
  input  logic [CNT_W-1:0]           len,
  output logic [3:0]                 mac_a,
  output logic [3:0]                 mac_b,
  output logic                       mac_issue,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam int DW = DRAIN > 1 ? $clog2(DRAIN) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t           state_q, state_d;
  logic [3:0]       mem_a_q [DEPTH];
  logic [3:0]       mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [3:0]       mac_a_q, mac_b_q;
  logic             issue_q, busy_q, done_q, done_d;
  logic             push, issue;
  assign in_ready   = level_q != (AW+1)'(DEPTH);
  assign push       = in_valid && in_ready;
  assign issue      = state_q == S_RUN && level_q != '0 && gap_q == '0;
  assign fifo_level = level_q;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_issue  = issue_q;
  assign busy       = busy_q;
  assign done       = done_q;
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q != '0 ? gap_q - 1'b1 : gap_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start && len != '0) begin
        state_d = S_RUN;
        rem_d   = len;
        gap_d   = '0;
      end
      S_RUN: if (issue) begin
        rem_d = rem_q - 1'b1;
        gap_d = GW'(GAP - 1);
        if (rem_q == CNT_W'(1)) begin
          state_d = S_DRAIN;
          drain_d = DW'(DRAIN - 1);
        end
      end
      S_DRAIN: begin
        done_d  = drain_q == '0;
        state_d = drain_q == '0 ? S_IDLE : S_DRAIN;
        drain_d = drain_q != '0 ? drain_q - 1'b1 : drain_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
    end
  end
  // busy stays high through the done cycle so both fall on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      drain_q  <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      issue_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_q  <= level_q + (AW+1)'(push) - (AW+1)'(issue);
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      drain_q  <= drain_d;
      mac_a_q  <= issue ? mem_a_q[rd_ptr_q] : '0;
      mac_b_q  <= issue ? mem_b_q[rd_ptr_q] : '0;
      issue_q  <= issue;
      busy_q   <= state_d != S_IDLE || done_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed scenario tests for mac_operand_feeder (GAP=2 and GAP=1 instances).
module tb_mac_operand_feeder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic       in_ready, mac_issue, busy, done;
  logic [3:0] mac_a, mac_b;
  logic [2:0] fifo_level;
  logic       in_ready1, mac_issue1, busy1, done1;
  logic [3:0] mac_a1, mac_b1;
  logic [2:0] fifo_level1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_operand_feeder #(.DEPTH(4), .CNT_W(4), .GAP(2), .DRAIN(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start), .len(len),
    .mac_a(mac_a), .mac_b(mac_b), .mac_issue(mac_issue), .busy(busy),
    .done(done), .fifo_level(fifo_level));

  mac_operand_feeder #(.DEPTH(4), .CNT_W(4), .GAP(1), .DRAIN(3)) dut_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .start(start), .len(len),
    .mac_a(mac_a1), .mac_b(mac_b1), .mac_issue(mac_issue1), .busy(busy1),
    .done(done1), .fifo_level(fifo_level1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({mac_a, mac_b, mac_issue, busy, done, in_ready, fifo_level} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++; $display("FAIL reset_init got a=%0d b=%0d iss=%0b busy=%0b done=%0b rdy=%0b lvl=%0d exp 0 0 0 0 0 1 0", mac_a, mac_b, mac_issue, busy, done, in_ready, fifo_level);
    end
    rst_n = 1'b1;
    tick();
    push(4'd6, 4'd7); push(4'd8, 4'd9); push(4'd10, 4'd11);
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({mac_issue, mac_a, fifo_level} !== {1'b1, 4'd6, 3'd2}) begin
      failures++; $display("FAIL reset_pre iss=%0b a=%0d lvl=%0d exp 1 6 2", mac_issue, mac_a, fifo_level);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mac_a, mac_b, mac_issue, busy, done, in_ready, fifo_level} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      failures++; $display("FAIL reset_async got a=%0d b=%0d iss=%0b busy=%0b done=%0b rdy=%0b lvl=%0d exp 0 0 0 0 0 1 0", mac_a, mac_b, mac_issue, busy, done, in_ready, fifo_level);
    end
    #2;
    rst_n = 1'b1;
    tick();
    start = 1'b1; len = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, mac_issue, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
        failures++; $display("FAIL reset_wait busy=%0b iss=%0b lvl=%0d exp 1 0 0", busy, mac_issue, fifo_level);
      end
    end
    push(4'd2, 4'd3);
    tick();
    checks++;
    if ({mac_issue, mac_a, mac_b} !== {1'b1, 4'd2, 4'd3}) begin
      failures++; $display("FAIL reset_newpush iss=%0b a=%0d b=%0d exp 1 2 3", mac_issue, mac_a, mac_b);
    end
    tick(); tick(); tick();
    checks++;
    if ({done, busy} !== 2'b11) begin
      failures++; $display("FAIL reset_done done=%0b busy=%0b exp 1 1", done, busy);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] ea [1:5];
    logic [3:0] eb [1:5];
    logic [7:0] acc;
    acc = '0;
    ea[1] = 4'd3; eb[1] = 4'd5; ea[3] = 4'd15; eb[3] = 4'd15; ea[5] = 4'd2; eb[5] = 4'd7;
    push(4'd3, 4'd5); push(4'd15, 4'd15); push(4'd2, 4'd7);
    checks++;
    if (fifo_level !== 3'd3) begin
      failures++; $display("FAIL basic_level got=%0d exp=3", fifo_level);
    end
    start = 1'b1; len = 4'd3;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, mac_issue} !== 2'b10) begin
      failures++; $display("FAIL basic_e0 busy=%0b iss=%0b exp 1 0", busy, mac_issue);
    end
    for (int k = 1; k <= 9; k++) begin
      logic       ei;
      logic [3:0] xa, xb;
      tick();
      ei = (k == 1 || k == 3 || k == 5);
      xa = ei ? ea[k] : 4'd0;
      xb = ei ? eb[k] : 4'd0;
      acc = acc + mac_a * mac_b;
      checks++;
      if ({mac_issue, mac_a, mac_b, done, busy} !== {ei, xa, xb, k == 8, k <= 8}) begin
        failures++; $display("FAIL basic_edge%0d iss=%0b a=%0d b=%0d done=%0b busy=%0b exp %0b %0d %0d %0b %0b", k, mac_issue, mac_a, mac_b, done, busy, ei, xa, xb, k == 8, k <= 8);
      end
    end
    checks++;
    if (acc !== 8'd254) begin
      failures++; $display("FAIL basic_acc got=%0d exp=254", acc);
    end
  endtask

  task automatic test_full_fifo();
    logic [3:0] got [4];
    int n;
    n = 0;
    for (int i = 1; i <= 4; i++) push(4'(i), 4'd1);
    checks++;
    if ({in_ready, fifo_level} !== {1'b0, 3'd4}) begin
      failures++; $display("FAIL full_flag rdy=%0b lvl=%0d exp 0 4", in_ready, fifo_level);
    end
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9;
    tick();
    start = 1'b1; len = 4'd5;
    tick();
    start = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++; $display("FAIL full_hold lvl=%0d exp 4", fifo_level);
    end
    tick();
    checks++;
    if ({mac_issue, mac_a, fifo_level, in_ready} !== {1'b1, 4'd1, 3'd3, 1'b1}) begin
      failures++; $display("FAIL full_pop iss=%0b a=%0d lvl=%0d rdy=%0b exp 1 1 3 1", mac_issue, mac_a, fifo_level, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      failures++; $display("FAIL full_accept lvl=%0d exp 4", fifo_level);
    end
    for (int c = 0; c < 30 && !done; c++) begin
      tick();
      if (mac_issue && n < 4) got[n] = mac_a;
      if (mac_issue) n++;
    end
    checks++;
    if ({done, 3'(n), got[0], got[1], got[2], got[3]} !== {1'b1, 3'd4, 4'd2, 4'd3, 4'd4, 4'd9}) begin
      failures++; $display("FAIL full_seq done=%0b n=%0d seq=%0d,%0d,%0d,%0d exp 1 4 2,3,4,9", done, n, got[0], got[1], got[2], got[3]);
    end
    tick();
  endtask

  task automatic test_starvation();
    push(4'd4, 4'd4);
    start = 1'b1; len = 4'd2;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({mac_issue, mac_a} !== {1'b1, 4'd4}) begin
      failures++; $display("FAIL starve_first iss=%0b a=%0d exp 1 4", mac_issue, mac_a);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({mac_issue, mac_a, mac_b, busy, done} !== {1'b0, 4'd0, 4'd0, 1'b1, 1'b0}) begin
        failures++; $display("FAIL starve_idle%0d iss=%0b a=%0d b=%0d busy=%0b done=%0b exp 0 0 0 1 0", i, mac_issue, mac_a, mac_b, busy, done);
      end
    end
    push(4'd1, 4'd1);
    checks++;
    if (mac_issue !== 1'b0) begin
      failures++; $display("FAIL starve_push iss=%0b exp 0", mac_issue);
    end
    tick();
    checks++;
    if ({mac_issue, mac_a, mac_b} !== {1'b1, 4'd1, 4'd1}) begin
      failures++; $display("FAIL starve_issue iss=%0b a=%0d b=%0d exp 1 1 1", mac_issue, mac_a, mac_b);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if ({done, busy} !== {k == 3, k <= 3}) begin
        failures++; $display("FAIL starve_drain%0d done=%0b busy=%0b exp %0b %0b", k, done, busy, k == 3, k <= 3);
      end
    end
  endtask

  task automatic test_ignored_starts();
    int n;
    n = 0;
    start = 1'b1; len = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy, done, mac_issue} !== 3'b000) begin
        failures++; $display("FAIL len0_%0d busy=%0b done=%0b iss=%0b exp 0 0 0", i, busy, done, mac_issue);
      end
    end
    push(4'd1, 4'd2); push(4'd1, 4'd3); push(4'd1, 4'd4);
    start = 1'b1; len = 4'd2;
    tick();
    len = 4'd15;
    for (int c = 0; c < 40 && !done; c++) begin
      start = (c % 2 == 0);
      tick();
      if (mac_issue) n++;
    end
    start = 1'b0;
    checks++;
    if ({done, n[3:0], fifo_level} !== {1'b1, 4'd2, 3'd1}) begin
      failures++; $display("FAIL run_start done=%0b issues=%0d lvl=%0d exp 1 2 1", done, n, fifo_level);
    end
    tick();
  endtask

  task automatic test_gap();
    do_reset();
    for (int i = 1; i <= 4; i++) push(4'(i), 4'd2);
    start = 1'b1; len = 4'd4;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic       ei;
      logic [3:0] xa;
      tick();
      ei = k <= 4;
      xa = ei ? 4'(k) : 4'd0;
      checks++;
      if ({mac_issue1, mac_a1, done1} !== {ei, xa, k == 7}) begin
        failures++; $display("FAIL gap1_edge%0d iss=%0b a=%0d done=%0b exp %0b %0d %0b", k, mac_issue1, mac_a1, done1, ei, xa, k == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_fifo();
    test_starvation();
    test_ignored_starts();
    test_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Upstream operand stage for the 4x4 multiply-accumulate datapath. Buffers incoming 4-bit A/B operand pairs in a small FIFO. Issues exactly `len` pairs to the MAC's A/B operand inputs, spaced by a programmable gap. Drives zero operands in every non-issue cycle so the free-running accumulator only adds zero, and signals completion once the MAC pipeline has drained.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, default 4: width of the term-count field `len`.
- `GAP`, default 2: minimum cycles between consecutive issues; at least 1. 2 matches the MAC's two-cycle accumulator feedback loop.
- `DRAIN`, default 3: cycles from the last issue edge to the `done` pulse; equals the MAC's operand-to-accumulator latency.

Ports:
- `clk` input, 1: clock, rising-edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `in_valid` input, 1: upstream has a pair on `in_a`/`in_b`.
- `in_ready` output, 1: FIFO can accept a pair; equals !full.
- `in_a` input, 4: operand A.
- `in_b` input, 4: operand B.
- `start` input, 1: begin a sequence of `len` terms; sampled only in IDLE.
- `len` input, CNT_W: number of terms; sampled with `start`.
- `mac_a` output, 4: registered operand A to the MAC; 0 when not issuing.
- `mac_b` output, 4: registered operand B to the MAC; 0 when not issuing.
- `mac_issue` output, 1: `mac_a`/`mac_b` carry a real pair this cycle.
- `busy` output, 1: state is RUN or DRAIN.
- `done` output, 1: one-cycle pulse when the sequence result is in the MAC accumulator.
- `fifo_level` output, log2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs at an edge where `in_valid && in_ready`.
  - Pushes are accepted in every state.
  - `in_ready` derives from registered occupancy. There is no bypass: a pop and a push in the same cycle when full does not admit the push.
  - Simultaneous push and pop when neither full nor empty leaves `fifo_level` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **FSM: IDLE, RUN, DRAIN.**
  - **IDLE**
    - `start` with `len` != 0: latch `remaining`=`len`, set `gap_cnt`=0, go to RUN.
    - `start` with `len`=0: ignored, stay in IDLE, no `done`.
  - **RUN**
    - Issue condition at an edge: FIFO not empty and `gap_cnt`==0.
    - On issue: pop the head into `mac_a`/`mac_b`, set `mac_issue`=1, decrement `remaining`, set `gap_cnt`=GAP-1.
    - At any other edge: `mac_a`=`mac_b`=0, `mac_issue`=0, and `gap_cnt` decrements if nonzero.
    - FIFO empty: stall indefinitely with zero outputs; no timeout.
    - The issue that takes `remaining` to 0 moves the FSM to DRAIN and loads `drain_cnt`=DRAIN-1.
  - **DRAIN**
    - Zero outputs; `drain_cnt` decrements each edge.
    - `done` is asserted for the one cycle in which `drain_cnt`==0; the FSM then returns to IDLE.
  - `start` in RUN or DRAIN is ignored.
- **Widths**
  - `remaining` is CNT_W bits and never underflows.
  - The feeder performs no arithmetic on operands; overflow of the MAC's 8-bit accumulator is not detected here.
- **Reset, asserted at any time (including mid-sequence)**
  - Clears the FIFO (pointers and level to 0) and returns the FSM to IDLE.
  - Output reset values: `mac_a`=0, `mac_b`=0, `mac_issue`=0, `busy`=0, `done`=0, `in_ready`=1, `fifo_level`=0.
  - Partially issued terms are abandoned.

## Timing
- All outputs are registered; there is no combinational path from input to output except that `in_ready` follows registered occupancy.
- `start` sampled at edge E: the FSM is in RUN after E. The earliest issue is edge E+1, so `mac_issue` is high during the cycle after E+1.
- Push at edge P into an empty FIFO while in RUN: the earliest pop is edge P+1.
- Back-to-back issues are exactly GAP edges apart when the FIFO stays non-empty.
- Last issue at edge L: `done` is high in the cycle following edge L+DRAIN; `busy` falls on the same edge `done` falls.
- `fifo_level` updates on the push/pop edge.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with 2 entries queued -> all outputs at their reset values immediately (asynchronously); after release `fifo_level`=0 and a `start` with `len`=1 waits for a new push.
- **Basic sequence:** push (3,5),(15,15),(2,7), then `start`, `len`=3 at edge 0 -> `mac_issue` pulses at edges 1, 3, 5 carrying those pairs, zeros between; `done` after edge 8; MAC accumulator sum = 15+225+14 = 254.
- **Full FIFO:** push 4 pairs while IDLE -> `in_ready`=0 and `fifo_level`=4; a 5th pair is held until the first pop, then accepted at the next edge.
- **Starvation:** `len`=2, only 1 pair queued -> one issue, then zero outputs with `busy`=1 for 10 cycles; pushing (1,1) issues it after GAP has elapsed and then `done` follows DRAIN edges later.
- **Ignored starts:** `start` with `len`=0 -> stays IDLE, no `done`. `start` pulsed during RUN -> `remaining` unaffected, total issues still equal the original `len`.
- **Gap:** with GAP=1 -> 4 queued pairs issue on 4 consecutive edges and `mac_issue` stays high for 4 cycles.
